prio_encoder_pipe: RTL and testbench
====================================

Name: prio_encoder_pipe

Overview:
- Parametrised, registered N-to-log2(N) priority encoder with valid/ready handshake on both sides.
- Successor to the fixed 8-to-3 combinational encoder:
  - any width;
  - defined output for zero and multi-hot inputs;
  - optional round-robin priority.
- Sits between request sources (interrupt lines, FIFO-not-empty flags) and a downstream consumer that takes one index per transfer.

Parameters:
- N, 8, request vector width; legal range 2..256.
- W, $clog2(N), index width; derived, not overridden.
- MODE, 0, 0 = fixed priority (highest index wins); 1 = round-robin.

Ports:
- iClk  input  1  clock, rising edge.
- iRst_n  input  1  asynchronous active-low reset.
- iData  input  N  request vector.
- iValid  input  1  iData valid this cycle.
- oReady  output  1  block can accept iData this cycle.
- oData  output  W  encoded index of winning bit.
- oHit  output  1  at least one request bit was set.
- oMulti  output  1  more than one request bit was set.
- oValid  output  1  oData/oHit/oMulti valid.
- iReady  input  1  consumer accepts output this cycle.

Behaviour:
- Clock and reset:
  - One clock: iClk.
  - Reset is asynchronous, active-low (iRst_n).
  - Asserting iRst_n low at any time (including mid-transfer) immediately forces oValid=0, oData=0, oHit=0, oMulti=0 and rr pointer = N-1.
  - Pending output is discarded on reset. Deassertion is released on the clock edge.
- Output stage:
  - One-entry output register.
  - oReady = !oValid || iReady (combinational; no registered ready).
- Transfers:
  - Accept when iValid && oReady. On accept, next edge loads encoded result and sets oValid=1.
  - Output consumed when oValid && iReady. If no accept on the same edge, oValid clears.
  - Simultaneous consume + accept: register reloads, oValid stays 1. Full throughput is 1 transfer/cycle.
- Latency: exactly 1 cycle from accepting edge to oValid high.
- Stall: while oValid && !iReady, oData/oHit/oMulti hold stable and iData is ignored.
- Zero input: oHit=0, oData=0, oMulti=0. Still a valid transfer; oValid asserts.
- oMulti: popcount(iData) > 1. Independent of MODE.
- MODE=0 (fixed priority):
  - oData = index of highest set bit.
  - Matches the 8-to-3 one-hot mapping for N=8.
- MODE=1 (round-robin):
  - Pointer ptr, width W, reset N-1.
  - Search starts at bit ptr, proceeds downward, wraps from 0 to N-1.
  - On an accepted transfer with oHit, ptr <= (k==0) ? N-1 : k-1, where k is the winner.
  - Zero-input transfers and stalled cycles leave ptr unchanged.
- Non-power-of-two N: indices >= N never produced; pointer wrap uses N-1, not 2^W-1.
- No X propagation: all outputs are defined for every iData value.

Optional Feature:
- Macro: PRIO_ENCODER_PIPE_MULTI_CNT_EN.
- Defined:
  - Adds output oMultiCnt [15:0].
  - Saturating counter of accepted transfers with oMulti=1.
  - Increments on the accepting edge; sticks at 16'hFFFF.
  - Reset to 0 by iRst_n.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package enc_pkg:
  - MODE_FIXED=0, MODE_RR=1 constants.
  - Clog2 helper function for W.
- Sub-module prio_find:
  - Purely combinational; params N, W.
  - Inputs: request vector, start index.
  - Outputs: index, hit, multi.
  - Searches downward from start with wrap.
- Top instantiates one prio_find:
  - start = N-1 for MODE=0; start = ptr for MODE=1.
  - Top owns the handshake register, pointer, and optional counter.

Test Plan:
- N=8, MODE=0, iValid=1, iReady=1, iData=8'b0010_0000 → next cycle oValid=1, oData=5, oHit=1, oMulti=0.
- N=8, MODE=0, iData=8'b0100_0110 → oData=6, oMulti=1. Then iData=8'h00 → oData=0, oHit=0, oValid=1.
- Hold iReady=0 after one accept with iData=8'h08 → oData=3 held, oReady=0. New iData=8'h80 ignored until iReady=1, then accepted; oData=7 one cycle later.
- N=8, MODE=1, iData=8'b1000_0001 for 3 accepted cycles → oData sequence 7, 0, 7.
- N=5, MODE=1, iData=5'b10001 repeated → oData 4, 0, 4. No index >4 ever appears.
- Pull iRst_n low mid-stream with oValid=1 → same-cycle oValid=0, outputs 0. After release, first RR result uses ptr=N-1.
- With PRIO_ENCODER_PIPE_MULTI_CNT_EN defined: 3 multi-hot accepts plus 2 one-hot accepts → oMultiCnt=3.

Source files
------------

// File: rtl/enc_pkg.sv
// -----------------------------------------------------------------------------
// enc_pkg
// Shared constants and helpers for the pipelined priority encoder.
//
// Contents:
//   MODE_FIXED / MODE_RR : values for the MODE parameter of prio_encoder_pipe.
//   clog2()              : ceiling log2, used to derive the index width W.
//
// Optional feature macro used elsewhere in this slice:
//   PRIO_ENCODER_PIPE_MULTI_CNT_EN (adds the multi-hot transfer counter).
// -----------------------------------------------------------------------------
package enc_pkg;

    // Priority selection modes.
    localparam int MODE_FIXED = 0;  // highest set index always wins
    localparam int MODE_RR    = 1;  // rotating start point after each hit

    // Legal request-vector widths.
    localparam int N_MIN = 2;
    localparam int N_MAX = 256;

    // Ceiling log2. Returns the number of bits needed to hold the values
    // 0..value-1, with a minimum of 1 so that N=2 still gets a 1-bit index.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage : enc_pkg

// File: rtl/prio_encoder_pipe_prio_find.sv
// -----------------------------------------------------------------------------
// prio_find
// Purely combinational priority search. Starting at bit 'start' it scans
// downward through the request vector, wrapping from bit 0 to bit N-1, and
// reports the first set bit it meets.
//
// Parameters:
//   N : request vector width (2..256).
//   W : index width, normally enc_pkg::clog2(N).
//
// Ports:
//   req   in  [N-1:0]  request vector
//   start in  [W-1:0]  first bit position examined
//   index out [W-1:0]  position of the winning bit (0 when no bit is set)
//   hit   out          at least one request bit is set
//   multi out          more than one request bit is set
// -----------------------------------------------------------------------------
module prio_find
    import enc_pkg::*;
#(
    parameter int N = 8,
    parameter int W = clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [W-1:0] index,
    output logic         hit,
    output logic         multi
);

    // A start value outside 0..N-1 can only occur for non-power-of-two N
    // if the caller misbehaves; clamp it to the top bit so the scan always
    // walks real request bits and never reports an index >= N.
    int start_pos;

    always_comb begin
        start_pos = int'(start);
        if (start_pos >= N) begin
            start_pos = N - 1;
        end
    end

    // Wrapped downward scan. The first match along the scan order wins;
    // later matches are ignored via the 'found' flag.
    always_comb begin
        logic found;
        int   pos;
        found = 1'b0;
        index = '0;
        pos   = 0;
        for (int i = 0; i < N; i++) begin
            pos = start_pos - i;
            if (pos < 0) begin
                pos = pos + N;
            end
            if (!found && req[pos]) begin
                found = 1'b1;
                index = W'(pos);
            end
        end
    end

    // Hit / multi-hot detection, independent of the scan order.
    always_comb begin
        logic seen;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < N; i++) begin
            multi = multi | (seen & req[i]);
            seen  = seen | req[i];
        end
        hit = seen;
    end

endmodule : prio_find

// File: rtl/prio_encoder_pipe.sv
// -----------------------------------------------------------------------------
// prio_encoder_pipe
// Registered N-to-log2(N) priority encoder with valid/ready handshakes on the
// input and output sides. One prio_find instance does the search; this module
// owns the one-entry output register, the round-robin pointer and the
// optional multi-hot counter.
//
// Parameters:
//   N    : request vector width, 2..256 (default 8).
//   MODE : MODE_FIXED (0) highest index wins; MODE_RR (1) round-robin.
//   W    : derived index width (localparam, clog2(N)).
//
// Ports:
//   iClk      in          rising-edge clock
//   iRst_n    in          asynchronous active-low reset
//   iData     in  [N-1:0] request vector
//   iValid    in          iData valid this cycle
//   oReady    out         block can accept iData this cycle
//   oData     out [W-1:0] encoded index of the winning bit
//   oHit      out         at least one request bit was set
//   oMulti    out         more than one request bit was set
//   oValid    out         oData/oHit/oMulti valid
//   iReady    in          consumer accepts the output this cycle
//   oMultiCnt out [15:0]  saturating count of accepted multi-hot transfers
//                         (present only with PRIO_ENCODER_PIPE_MULTI_CNT_EN)
//
// Configuration macro: PRIO_ENCODER_PIPE_MULTI_CNT_EN
//
// Handshake: a transfer happens on an input side when iValid && oReady at a
// rising edge, and on the output side when oValid && iReady at a rising edge.
// Valid, once raised, is held with stable data until the matching ready is
// seen; ready may depend combinationally on the consumer's ready, and a side
// never waits for the other side's valid before raising its own ready.
// -----------------------------------------------------------------------------
module prio_encoder_pipe
    import enc_pkg::*;
#(
    parameter int N    = 8,
    parameter int MODE = MODE_FIXED
) (
    input  logic                     iClk,
    input  logic                     iRst_n,
    input  logic [N-1:0]             iData,
    input  logic                     iValid,
    output logic                     oReady,
    output logic [clog2(N)-1:0]      oData,
    output logic                     oHit,
    output logic                     oMulti,
    output logic                     oValid,
    input  logic                     iReady
`ifdef PRIO_ENCODER_PIPE_MULTI_CNT_EN
    ,
    output logic [15:0]              oMultiCnt
`endif
);

    localparam int W = clog2(N);

    // Top legal index; also the reset value and wrap target of the pointer.
    localparam logic [W-1:0] TOP_IDX = W'(N - 1);

    logic [W-1:0] ptr;
    logic [W-1:0] search_start;
    logic [W-1:0] win_idx;
    logic         win_hit;
    logic         win_multi;
    logic         accept;

    // The output register can take a new result whenever it is empty or
    // is being drained on this same edge.
    assign oReady = !oValid || iReady;
    assign accept = iValid && oReady;

    // Fixed priority always scans from the top bit; round-robin scans from
    // the pointer, which sits just below the previous winner.
    assign search_start = (MODE == MODE_RR) ? ptr : TOP_IDX;

    prio_find #(
        .N (N),
        .W (W)
    ) u_find (
        .req   (iData),
        .start (search_start),
        .index (win_idx),
        .hit   (win_hit),
        .multi (win_multi)
    );

    // Output register and valid flag. While stalled (oValid && !iReady)
    // accept is low, so the register holds and iData is ignored.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oValid <= 1'b0;
            oData  <= '0;
            oHit   <= 1'b0;
            oMulti <= 1'b0;
        end else if (accept) begin
            oValid <= 1'b1;
            oData  <= win_idx;
            oHit   <= win_hit;
            oMulti <= win_multi;
        end else if (iReady) begin
            oValid <= 1'b0;
        end
    end

    // Round-robin pointer. Moves only on an accepted transfer that found a
    // request; it then points one below the winner so the winner becomes
    // lowest priority. Wrap goes to N-1, not 2^W-1, for non-power-of-two N.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            ptr <= TOP_IDX;
        end else if ((MODE == MODE_RR) && accept && win_hit) begin
            if (win_idx == '0) begin
                ptr <= TOP_IDX;
            end else begin
                ptr <= win_idx - W'(1);
            end
        end
    end

`ifdef PRIO_ENCODER_PIPE_MULTI_CNT_EN
    // Saturating count of accepted multi-hot transfers; sticks at all-ones.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oMultiCnt <= '0;
        end else if (accept && win_multi && (oMultiCnt != 16'hFFFF)) begin
            oMultiCnt <= oMultiCnt + 16'd1;
        end
    end
`endif

endmodule : prio_encoder_pipe

// File: tb/tb_prio_encoder_pipe.sv
// -----------------------------------------------------------------------------
// tb_prio_encoder_pipe
// Directed self-checking bench. Three instances of prio_encoder_pipe:
//   u_fx  : N=8, fixed priority
//   u_rr8 : N=8, round-robin
//   u_rr5 : N=5, round-robin
// Inputs change 1 time unit after the rising edge; outputs are sampled there
// too, well away from the next active edge.
// -----------------------------------------------------------------------------
module tb_prio_encoder_pipe;
    import enc_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;

    // ---------------- DUT signals ----------------
    logic [7:0] fx_data;
    logic       fx_valid, fx_ready, fx_oready, fx_ovalid, fx_hit, fx_multi;
    logic [2:0] fx_idx;

    logic [7:0] r8_data;
    logic       r8_valid, r8_ready, r8_oready, r8_ovalid, r8_hit, r8_multi;
    logic [2:0] r8_idx;

    logic [4:0] r5_data;
    logic       r5_valid, r5_ready, r5_oready, r5_ovalid, r5_hit, r5_multi;
    logic [2:0] r5_idx;

`ifdef PRIO_ENCODER_PIPE_MULTI_CNT_EN
    logic [15:0] fx_cnt, r8_cnt, r5_cnt;
`endif

    prio_encoder_pipe #(.N(8), .MODE(MODE_FIXED)) u_fx (
        .iClk(clk), .iRst_n(rst_n), .iData(fx_data), .iValid(fx_valid),
        .oReady(fx_oready), .oData(fx_idx), .oHit(fx_hit), .oMulti(fx_multi),
        .oValid(fx_ovalid), .iReady(fx_ready)
`ifdef PRIO_ENCODER_PIPE_MULTI_CNT_EN
        , .oMultiCnt(fx_cnt)
`endif
    );

    prio_encoder_pipe #(.N(8), .MODE(MODE_RR)) u_rr8 (
        .iClk(clk), .iRst_n(rst_n), .iData(r8_data), .iValid(r8_valid),
        .oReady(r8_oready), .oData(r8_idx), .oHit(r8_hit), .oMulti(r8_multi),
        .oValid(r8_ovalid), .iReady(r8_ready)
`ifdef PRIO_ENCODER_PIPE_MULTI_CNT_EN
        , .oMultiCnt(r8_cnt)
`endif
    );

    prio_encoder_pipe #(.N(5), .MODE(MODE_RR)) u_rr5 (
        .iClk(clk), .iRst_n(rst_n), .iData(r5_data), .iValid(r5_valid),
        .oReady(r5_oready), .oData(r5_idx), .oHit(r5_hit), .oMulti(r5_multi),
        .oValid(r5_ovalid), .iReady(r5_ready)
`ifdef PRIO_ENCODER_PIPE_MULTI_CNT_EN
        , .oMultiCnt(r5_cnt)
`endif
    );

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        fx_data = '0; fx_valid = 1'b0; fx_ready = 1'b1;
        r8_data = '0; r8_valid = 1'b0; r8_ready = 1'b1;
        r5_data = '0; r5_valid = 1'b0; r5_ready = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_all();
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if ({fx_ovalid, fx_idx, fx_hit, fx_multi} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_fx: got v=%b d=%0d h=%b m=%b, want all 0", fx_ovalid, fx_idx, fx_hit, fx_multi);
        end
        n_cmp++;
        if ({r8_ovalid, r8_idx, r5_ovalid, r5_idx} !== 8'b0) begin
            n_err++;
            $display("FAIL reset_rr: got r8 v=%b d=%0d r5 v=%b d=%0d, want 0", r8_ovalid, r8_idx, r5_ovalid, r5_idx);
        end
        n_cmp++;
        if (fx_oready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_oready: got %b want 1", fx_oready);
        end
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fixed();
        logic [7:0] vec [3];
        logic [2:0] e_idx [3];
        logic       e_hit [3];
        logic       e_mul [3];
        vec[0] = 8'b0010_0000; e_idx[0] = 3'd5; e_hit[0] = 1'b1; e_mul[0] = 1'b0;
        vec[1] = 8'b0100_0110; e_idx[1] = 3'd6; e_hit[1] = 1'b1; e_mul[1] = 1'b1;
        vec[2] = 8'h00;        e_idx[2] = 3'd0; e_hit[2] = 1'b0; e_mul[2] = 1'b0;
        fx_ready = 1'b1;
        fx_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fx_data = vec[i];
            tick();
            n_cmp++;
            if ({fx_ovalid, fx_idx, fx_hit, fx_multi} !== {1'b1, e_idx[i], e_hit[i], e_mul[i]}) begin
                n_err++;
                $display("FAIL fixed_%0d: got v=%b d=%0d h=%b m=%b, want v=1 d=%0d h=%b m=%b",
                         i, fx_ovalid, fx_idx, fx_hit, fx_multi, e_idx[i], e_hit[i], e_mul[i]);
            end
        end
        fx_valid = 1'b0;
        tick();
        n_cmp++;
        if (fx_ovalid !== 1'b0) begin
            n_err++;
            $display("FAIL fixed_drain: got oValid=%b want 0", fx_ovalid);
        end
    endtask

    task automatic test_stall();
        fx_ready = 1'b0;
        fx_valid = 1'b1;
        fx_data  = 8'h08;
        tick();
        n_cmp++;
        if ({fx_ovalid, fx_idx, fx_oready} !== {1'b1, 3'd3, 1'b0}) begin
            n_err++;
            $display("FAIL stall_load: got v=%b d=%0d rdy=%b, want v=1 d=3 rdy=0", fx_ovalid, fx_idx, fx_oready);
        end
        fx_data = 8'h80;
        tick();
        tick();
        n_cmp++;
        if ({fx_ovalid, fx_idx, fx_hit, fx_multi, fx_oready} !== {1'b1, 3'd3, 1'b1, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL stall_hold: got v=%b d=%0d h=%b m=%b rdy=%b, want v=1 d=3 h=1 m=0 rdy=0",
                     fx_ovalid, fx_idx, fx_hit, fx_multi, fx_oready);
        end
        fx_ready = 1'b1;
        #1;
        n_cmp++;
        if (fx_oready !== 1'b1) begin
            n_err++;
            $display("FAIL stall_release_rdy: got %b want 1", fx_oready);
        end
        tick();
        n_cmp++;
        if ({fx_ovalid, fx_idx} !== {1'b1, 3'd7}) begin
            n_err++;
            $display("FAIL stall_release: got v=%b d=%0d, want v=1 d=7", fx_ovalid, fx_idx);
        end
        fx_valid = 1'b0;
        tick();
    endtask

    task automatic test_rr8();
        logic [7:0] vec [5];
        logic [2:0] e_idx [5];
        logic       e_hit [5];
        // Pointer starts at 7: 7 wins, ptr->6; 0 wins, ptr->7; 7 wins, ptr->6;
        // zero input leaves ptr at 6; so the next two-hot vector gives 0.
        vec[0] = 8'b1000_0001; e_idx[0] = 3'd7; e_hit[0] = 1'b1;
        vec[1] = 8'b1000_0001; e_idx[1] = 3'd0; e_hit[1] = 1'b1;
        vec[2] = 8'b1000_0001; e_idx[2] = 3'd7; e_hit[2] = 1'b1;
        vec[3] = 8'h00;        e_idx[3] = 3'd0; e_hit[3] = 1'b0;
        vec[4] = 8'b1000_0001; e_idx[4] = 3'd0; e_hit[4] = 1'b1;
        r8_ready = 1'b1;
        r8_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            r8_data = vec[i];
            tick();
            n_cmp++;
            if ({r8_ovalid, r8_idx, r8_hit, r8_multi} !== {1'b1, e_idx[i], e_hit[i], e_hit[i]}) begin
                n_err++;
                $display("FAIL rr8_%0d: got v=%b d=%0d h=%b m=%b, want v=1 d=%0d h=%b m=%b",
                         i, r8_ovalid, r8_idx, r8_hit, r8_multi, e_idx[i], e_hit[i], e_hit[i]);
            end
        end
        r8_valid = 1'b0;
        tick();
    endtask

    task automatic test_rr5();
        logic [4:0] vec [8];
        logic [2:0] e_idx [8];
        // 10001: 4 (ptr 3), 0 (ptr 4), 4 (ptr 3); then all ones walks
        // 3, 2, 1, 0 and wraps to 4 rather than 7.
        vec[0] = 5'b10001; e_idx[0] = 3'd4;
        vec[1] = 5'b10001; e_idx[1] = 3'd0;
        vec[2] = 5'b10001; e_idx[2] = 3'd4;
        vec[3] = 5'b11111; e_idx[3] = 3'd3;
        vec[4] = 5'b11111; e_idx[4] = 3'd2;
        vec[5] = 5'b11111; e_idx[5] = 3'd1;
        vec[6] = 5'b11111; e_idx[6] = 3'd0;
        vec[7] = 5'b11111; e_idx[7] = 3'd4;
        r5_ready = 1'b1;
        r5_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            r5_data = vec[i];
            tick();
            n_cmp++;
            if ({r5_ovalid, r5_idx, r5_hit, r5_multi} !== {1'b1, e_idx[i], 1'b1, 1'b1}) begin
                n_err++;
                $display("FAIL rr5_%0d: got v=%b d=%0d h=%b m=%b, want v=1 d=%0d h=1 m=1",
                         i, r5_ovalid, r5_idx, r5_hit, r5_multi, e_idx[i]);
            end
        end
        r5_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        // Move the pointer off N-1 and leave a result pending.
        r8_ready = 1'b1;
        r8_valid = 1'b1;
        r8_data  = 8'b1000_0001;
        tick();
        tick();
        r8_ready = 1'b0;
        tick();
        // ptr is now 7 after two transfers (7 then 0); do one more so ptr=6.
        r8_ready = 1'b1;
        tick();
        r8_valid = 1'b0;
        r8_ready = 1'b0;
        n_cmp++;
        if ({r8_ovalid, r8_idx} !== {1'b1, 3'd7}) begin
            n_err++;
            $display("FAIL rstmid_pre: got v=%b d=%0d, want v=1 d=7", r8_ovalid, r8_idx);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({r8_ovalid, r8_idx, r8_hit, r8_multi} !== 6'b0) begin
            n_err++;
            $display("FAIL rstmid_async: got v=%b d=%0d h=%b m=%b, want all 0", r8_ovalid, r8_idx, r8_hit, r8_multi);
        end
        #2 rst_n = 1'b1;
        r8_ready = 1'b1;
        r8_valid = 1'b1;
        r8_data  = 8'b1000_0001;
        tick();
        n_cmp++;
        if ({r8_ovalid, r8_idx} !== {1'b1, 3'd7}) begin
            n_err++;
            $display("FAIL rstmid_ptr: got v=%b d=%0d, want v=1 d=7", r8_ovalid, r8_idx);
        end
        r8_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] vec [5];
        logic [2:0] e_idx [5];
        logic       e_mul [5];
        vec[0] = 8'hFF;        e_idx[0] = 3'd7; e_mul[0] = 1'b1;
        vec[1] = 8'h03;        e_idx[1] = 3'd1; e_mul[1] = 1'b1;
        vec[2] = 8'h01;        e_idx[2] = 3'd0; e_mul[2] = 1'b0;
        vec[3] = 8'b0011_0000; e_idx[3] = 3'd5; e_mul[3] = 1'b1;
        vec[4] = 8'h10;        e_idx[4] = 3'd4; e_mul[4] = 1'b0;
        fx_ready = 1'b1;
        fx_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            fx_data = vec[i];
            tick();
            n_cmp++;
            if ({fx_ovalid, fx_idx, fx_hit, fx_multi, fx_oready} !== {1'b1, e_idx[i], 1'b1, e_mul[i], 1'b1}) begin
                n_err++;
                $display("FAIL b2b_%0d: got v=%b d=%0d h=%b m=%b rdy=%b, want v=1 d=%0d h=1 m=%b rdy=1",
                         i, fx_ovalid, fx_idx, fx_hit, fx_multi, fx_oready, e_idx[i], e_mul[i]);
            end
        end
        fx_valid = 1'b0;
        tick();
`ifdef PRIO_ENCODER_PIPE_MULTI_CNT_EN
        // Counter was cleared by the reset in test_reset_mid; 3 multi-hot
        // accepts in the run above.
        n_cmp++;
        if (fx_cnt !== 16'd3) begin
            n_err++;
            $display("FAIL multi_cnt: got %0d want 3", fx_cnt);
        end
`endif
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_fixed();
        test_stall();
        test_rr8();
        test_rr5();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_prio_encoder_pipe
